// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// rr_pick scans start, start+1, start+2, start+3 (mod 4) and returns the first set request.
package mux4_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] start);
    rr_pick_t   r;
    logic [1:0] i;
    r = '0;
    // Walk from the far end so the closest position to start is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = start + 2'(k);
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_data.sv
// Combinational 4:1 data mux; output forced to zero when not enabled.
module mux4_data
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [N_REQ*WIDTH-1:0] din,
  input  logic [1:0]             sel,
  input  logic                   en,
  output logic [WIDTH-1:0]       dout
);

  logic [WIDTH-1:0] words [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign words[gi] = din[gi*WIDTH +: WIDTH];
  end

  assign dout = en ? words[sel] : '0;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux, with a bounded hold time per grant
// whenever another requester is waiting.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [1:0]             sel,
  output logic                   busy,
  output logic [WIDTH-1:0]       dout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t       state_reg, state_next;
  logic [1:0]       owner_reg, owner_next;
  logic [1:0]       last_reg, last_next;
  logic [1:0]       sel_reg, sel_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [7:0]       hold_cnt_reg, hold_cnt_next;

  logic [N_REQ-1:0] others;
  rr_pick_t         idle_pick;
  rr_pick_t         sw_pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= 2'd0;
      last_reg     <= 2'd3;
      sel_reg      <= 2'd0;
      gnt_reg      <= '0;
      hold_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      sel_reg      <= sel_next;
      gnt_reg      <= gnt_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    sel_next      = sel_reg;
    gnt_next      = gnt_reg;
    hold_cnt_next = hold_cnt_reg;

    // The owner never competes against itself, so handoffs search only the others.
    others    = req & ~(N_REQ'(1) << owner_reg);
    idle_pick = rr_pick(req, last_reg + 2'd1);
    sw_pick   = rr_pick(others, owner_reg + 2'd1);

    case (state_reg)
      IDLE: begin
        if (idle_pick.found) begin
          state_next    = GRANT;
          owner_next    = idle_pick.idx;
          sel_next      = idle_pick.idx;
          gnt_next      = N_REQ'(1) << idle_pick.idx;
          hold_cnt_next = 8'd0;
        end
      end
      GRANT: begin
        if (!req[owner_reg]) begin
          last_next     = owner_reg;
          hold_cnt_next = 8'd0;
          if (sw_pick.found) begin
            owner_next = sw_pick.idx;
            sel_next   = sw_pick.idx;
            gnt_next   = N_REQ'(1) << sw_pick.idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (others == '0) begin
          // Saturate so a late competitor takes over on its first edge.
          if (hold_cnt_reg < HOLD_LAST) hold_cnt_next = hold_cnt_reg + 8'd1;
        end else if (hold_cnt_reg >= HOLD_LAST) begin
          last_next     = owner_reg;
          owner_next    = sw_pick.idx;
          sel_next      = sw_pick.idx;
          gnt_next      = N_REQ'(1) << sw_pick.idx;
          hold_cnt_next = 8'd0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = (state_reg == GRANT);

  mux4_data #(
    .WIDTH(WIDTH)
  ) u_data (
    .din (din),
    .sel (sel_reg),
    .en  (busy),
    .dout(dout)
  );

endmodule
